// File: rtl/uart16550_tx_ctrl.sv
// Bus master that programs a 16550 UART register file and then feeds it bytes
// from a valid/ready producer, polling LSR.THRE ahead of every THR write.
module uart16550_tx_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h1000,
  parameter logic [15:0] DIVISOR   = 16'd54,
  parameter logic [7:0]  LCR_VALUE = 8'h03,
  parameter logic [7:0]  IER_VALUE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        init_done,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [31:0] OFS_THR_DLL = 32'h00;
  localparam logic [31:0] OFS_IER_DLM = 32'h04;
  localparam logic [31:0] OFS_LCR     = 32'h0C;
  localparam logic [31:0] OFS_LSR     = 32'h14;
  localparam int unsigned LSR_THRE    = 5;

  typedef enum logic [2:0] {
    S_INIT_LCR_DLAB,
    S_INIT_DLL,
    S_INIT_DLM,
    S_INIT_LCR,
    S_INIT_IER,
    S_IDLE,
    S_POLL_LSR,
    S_WR_THR
  } state_t;

  state_t      state_q, state_d;
  logic        req_d, we_d, tx_ready_d, init_done_d;
  logic [31:0] addr_d, wdata_d;

  logic        st_we;
  logic [31:0] st_ofs;
  logic [7:0]  st_byte;

  logic        unused_rdata_bits;
  assign unused_rdata_bits = ^{bus_rdata[31:LSR_THRE+1], bus_rdata[LSR_THRE-1:0]};

  // Transaction each bus-owning state issues; WR_THR reuses the byte captured on entry.
  always_comb begin
    st_we   = 1'b0;
    st_ofs  = '0;
    st_byte = '0;
    unique case (state_q)
      S_INIT_LCR_DLAB: begin st_we = 1'b1; st_ofs = OFS_LCR;     st_byte = LCR_VALUE | 8'h80; end
      S_INIT_DLL:      begin st_we = 1'b1; st_ofs = OFS_THR_DLL; st_byte = DIVISOR[7:0];      end
      S_INIT_DLM:      begin st_we = 1'b1; st_ofs = OFS_IER_DLM; st_byte = DIVISOR[15:8];     end
      S_INIT_LCR:      begin st_we = 1'b1; st_ofs = OFS_LCR;     st_byte = LCR_VALUE;         end
      S_INIT_IER:      begin st_we = 1'b1; st_ofs = OFS_IER_DLM; st_byte = IER_VALUE;         end
      S_POLL_LSR:      begin st_we = 1'b0; st_ofs = OFS_LSR;     st_byte = '0;                end
      S_WR_THR:        begin st_we = 1'b1; st_ofs = OFS_THR_DLL; st_byte = bus_wdata[7:0];    end
      default:         begin st_we = 1'b0; st_ofs = '0;          st_byte = '0;                end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    req_d       = bus_req;
    we_d        = bus_we;
    addr_d      = bus_addr;
    wdata_d     = bus_wdata;
    tx_ready_d  = 1'b0;
    init_done_d = init_done;

    if (state_q == S_IDLE) begin
      // IDLE launches the LSR read directly so a byte costs no extra cycle here.
      if (init_done && tx_valid) begin
        state_d = S_POLL_LSR;
        req_d   = 1'b1;
        we_d    = 1'b0;
        addr_d  = BASE_ADDR + OFS_LSR;
        wdata_d = '0;
      end
    end else if (!bus_req) begin
      req_d   = 1'b1;
      we_d    = st_we;
      addr_d  = BASE_ADDR + st_ofs;
      wdata_d = {24'h0, st_byte};
    end else if (bus_ack) begin
      req_d = 1'b0;
      unique case (state_q)
        S_INIT_LCR_DLAB: state_d = S_INIT_DLL;
        S_INIT_DLL:      state_d = S_INIT_DLM;
        S_INIT_DLM:      state_d = S_INIT_LCR;
        S_INIT_LCR:      state_d = S_INIT_IER;
        S_INIT_IER: begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
        S_POLL_LSR: begin
          if (bus_rdata[LSR_THRE]) begin
            if (tx_valid) begin
              state_d = S_WR_THR;
              wdata_d = {24'h0, tx_data};
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_WR_THR: begin
          state_d    = S_IDLE;
          tx_ready_d = 1'b1;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_INIT_LCR_DLAB;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      tx_ready  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_req   <= req_d;
      bus_we    <= we_d;
      bus_addr  <= addr_d;
      bus_wdata <= wdata_d;
      tx_ready  <= tx_ready_d;
      init_done <= init_done_d;
    end
  end

endmodule

// File: tb/tb_uart16550_tx_ctrl.sv
// Self-checking bench for uart16550_tx_ctrl: bus slave model with LSR response
// queue, transaction log, directed table rows and a randomized byte stream.
module tb_uart16550_tx_ctrl;

  localparam logic [31:0] A_THR = 32'h1000;
  localparam logic [31:0] A_DLL = 32'h1000;
  localparam logic [31:0] A_IER = 32'h1004;
  localparam logic [31:0] A_DLM = 32'h1004;
  localparam logic [31:0] A_LCR = 32'h100C;
  localparam logic [31:0] A_LSR = 32'h1014;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_ready, init_done, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  always #5 clk = ~clk;

  uart16550_tx_ctrl #(
    .BASE_ADDR(32'h1000),
    .DIVISOR  (16'd54),
    .LCR_VALUE(8'h03),
    .IER_VALUE(8'h00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .init_done(init_done),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_ack  (bus_ack),
    .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    int unsigned delay;
    logic [7:0]  data;
    int unsigned n_busy;
    bit          drop;
    int unsigned exp_lsr;
    int unsigned exp_thr;
    int unsigned exp_ready;
    int unsigned exp_lat;
  } vec_t;

  txn_t        log_q[$];
  txn_t        exp_q[$];
  logic [7:0]  lsr_q[$];
  logic [7:0]  s_data[$];
  int unsigned s_gap[$];
  int unsigned s_busy[$];
  int unsigned ready_times[$];
  vec_t        vt[7];

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;
  int unsigned ready_total = 0;
  int unsigned ack_delay = 0;
  bit          rand_delay = 1'b0;
  bit          stray_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic we, input logic [31:0] a, input logic [7:0] d);
    txn_t t;
    t.we = we;
    t.addr = a;
    t.data = {24'h0, d};
    exp_q.push_back(t);
  endtask

  task automatic build_init_exp();
    exp_q.delete();
    push_exp(1'b1, A_LCR, 8'h83);
    push_exp(1'b1, A_DLL, 8'h36);
    push_exp(1'b1, A_DLM, 8'h00);
    push_exp(1'b1, A_LCR, 8'h03);
    push_exp(1'b1, A_IER, 8'h00);
  endtask

  task automatic compare_log(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_txn_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_we[%0d]", tag, i), 32'(log_q[i].we), 32'(exp_q[i].we));
      check($sformatf("%s_addr[%0d]", tag, i), log_q[i].addr, exp_q[i].addr);
      check($sformatf("%s_data[%0d]", tag, i), log_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic wait_init(input string tag, input int unsigned exp_cycle);
    int unsigned k;
    k = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      k++;
      if (init_done) break;
    end
    check({tag, "_init_latency"}, k, exp_cycle);
  endtask

  // Leaves the bench at negedge+1 of the last reset cycle; next negedge is cycle 1.
  task automatic do_reset(input int unsigned cycles);
    @(negedge clk);
    #1;
    rst = 1'b1;
    tx_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    #1;
    rst = 1'b0;
    log_q.delete();
  endtask

  task automatic run_stream(input string tag);
    int unsigned cyc;
    bit          done;
    cyc = 0;
    exp_q.delete();
    log_q.delete();
    ready_times.delete();
    lsr_q.delete();
    for (int i = 0; i < s_data.size(); i++) begin
      for (int b = 0; b < int'(s_busy[i]); b++) begin
        lsr_q.push_back(8'($urandom) & 8'hDF);
        push_exp(1'b0, A_LSR, 8'h00);
      end
      lsr_q.push_back(8'($urandom) | 8'h20);
      push_exp(1'b0, A_LSR, 8'h00);
      push_exp(1'b1, A_THR, s_data[i]);
    end
    @(negedge clk);
    for (int i = 0; i < s_data.size(); i++) begin
      for (int g = 0; g < int'(s_gap[i]); g++) begin
        @(negedge clk);
        cyc++;
      end
      tx_data = s_data[i];
      tx_valid = 1'b1;
      done = 1'b0;
      for (int k = 0; k < 500 && !done; k++) begin
        @(negedge clk);
        cyc++;
        if (tx_ready) begin
          done = 1'b1;
          tx_valid = 1'b0;
          ready_times.push_back(cyc);
        end else if (bus_req && bus_we && bus_addr == A_THR) begin
          tx_data = tx_data ^ 8'hFF;
        end
      end
      check($sformatf("%s_byte%0d_ready_seen", tag, i), 32'(done), 32'd1);
      if (!done) break;
    end
    tx_valid = 1'b0;
    repeat (8) @(negedge clk);
    check({tag, "_ready_count"}, 32'(ready_times.size()), 32'(s_data.size()));
    compare_log(tag);
  endtask

  // Bus slave: per-transaction ack delay, LSR answers popped from lsr_q, optional stray acks.
  initial begin
    int unsigned wait_cnt;
    int unsigned cur_delay;
    bit          in_txn;
    logic [31:0] r;
    wait_cnt = 0;
    cur_delay = 0;
    in_txn = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      r = $urandom;
      if (rst || !bus_req) begin
        in_txn = 1'b0;
        bus_ack = !rst && stray_en && ($urandom_range(0, 3) == 0);
        bus_rdata = r;
      end else begin
        if (!in_txn) begin
          in_txn = 1'b1;
          wait_cnt = 0;
          cur_delay = rand_delay ? $urandom_range(0, 3) : ack_delay;
        end
        if (wait_cnt >= cur_delay) begin
          bus_ack = 1'b1;
          in_txn = 1'b0;
          if (!bus_we && bus_addr == A_LSR) begin
            if (lsr_q.size() > 0) r[7:0] = lsr_q.pop_front();
            else r[7:0] = 8'h60;
          end
          bus_rdata = r;
        end else begin
          bus_ack = 1'b0;
          wait_cnt++;
          bus_rdata = r;
        end
      end
    end
  end

  // Bus monitor: logs completed transactions and checks hold/gap/wdata rules every cycle.
  initial begin
    logic        p_req, p_ack, p_we, p_rst;
    logic [31:0] p_addr, p_wdata;
    txn_t        t;
    p_req = 1'b0; p_ack = 1'b0; p_we = 1'b0; p_rst = 1'b1;
    p_addr = '0; p_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && !p_rst) begin
        if (p_req && p_ack) check("gap_after_ack", 32'(bus_req), 32'd0);
        if (p_req && !p_ack) begin
          check("req_hold", 32'(bus_req), 32'd1);
          check("we_hold", 32'(bus_we), 32'(p_we));
          check("addr_hold", bus_addr, p_addr);
          check("wdata_hold", bus_wdata, p_wdata);
        end
        if (bus_req) check("wdata_upper_zero", {8'h0, bus_wdata[31:8]}, 32'd0);
        if (bus_req && !bus_we) check("read_wdata_zero", bus_wdata, 32'd0);
      end
      if (!rst && bus_req && bus_ack) begin
        t.we = bus_we;
        t.addr = bus_addr;
        t.data = bus_wdata;
        log_q.push_back(t);
      end
      if (tx_ready) ready_total++;
      p_req = bus_req; p_ack = bus_ack; p_we = bus_we; p_rst = rst;
      p_addr = bus_addr; p_wdata = bus_wdata;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        v;
    int unsigned cyc, lat, rdy, rt0;
    bit          found;

    vt[0] = '{0, 8'h55, 2, 1'b0, 3, 1, 1, 9};
    vt[1] = '{0, 8'hA1, 0, 1'b0, 1, 1, 1, 5};
    vt[2] = '{3, 8'h3C, 0, 1'b0, 1, 1, 1, 11};
    vt[3] = '{1, 8'hC3, 1, 1'b0, 2, 1, 1, 10};
    vt[4] = '{2, 8'h00, 0, 1'b0, 1, 1, 1, 9};
    vt[5] = '{0, 8'hFF, 0, 1'b1, 1, 0, 0, 0};
    vt[6] = '{1, 8'h5A, 1, 1'b1, 2, 0, 0, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);

    // Zero-wait init: requests on odd cycles, init_done from cycle 10
    ack_delay = 0;
    #1;
    rst = 1'b0;
    log_q.delete();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("init0_req_c%0d", k), 32'(bus_req), 32'((k % 2 == 1) ? 1 : 0));
      check($sformatf("init0_done_c%0d", k), 32'(init_done), 32'((k >= 10) ? 1 : 0));
    end
    build_init_exp();
    compare_log("init0");

    // Table rows: single byte with given ack delay, busy LSR count and optional drop
    for (int r = 0; r < 7; r++) begin
      v = vt[r];
      @(negedge clk);
      ack_delay = v.delay;
      rand_delay = 1'b0;
      lsr_q.delete();
      for (int b = 0; b < int'(v.n_busy); b++) lsr_q.push_back(8'h00);
      lsr_q.push_back(8'h60);
      log_q.delete();
      tx_data = v.data;
      tx_valid = 1'b1;
      cyc = 1;
      lat = 0;
      rdy = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        cyc++;
        if (tx_ready) begin
          rdy++;
          if (lat == 0) lat = cyc;
          tx_valid = 1'b0;
        end else if (v.drop && bus_req && !bus_we &&
                     (lsr_q.size() + (bus_ack ? 1 : 0) == 1)) begin
          tx_valid = 1'b0;
        end
        if (bus_req && bus_we && bus_addr == A_THR) tx_data = tx_data ^ 8'hFF;
      end
      check($sformatf("row%0d_latency", r), lat, v.exp_lat);
      check($sformatf("row%0d_ready_count", r), rdy, v.exp_ready);
      exp_q.delete();
      for (int n = 0; n < int'(v.exp_lsr); n++) push_exp(1'b0, A_LSR, 8'h00);
      if (v.exp_thr != 0) push_exp(1'b1, A_THR, v.data);
      compare_log($sformatf("row%0d", r));
    end

    // Back-to-back stream with THRE always set
    ack_delay = 0;
    rand_delay = 1'b0;
    s_data = '{8'hA1, 8'hA2, 8'hA3};
    s_gap = '{0, 0, 0};
    s_busy = '{0, 0, 0};
    run_stream("b2b");
    if (ready_times.size() == 3) begin
      check("b2b_first_ready", ready_times[0], 32'd4);
      check("b2b_spacing_1", ready_times[1] - ready_times[0], 32'd4);
      check("b2b_spacing_2", ready_times[2] - ready_times[1], 32'd4);
    end

    // Randomized stream: random ack delays, stray acks, busy polls and gaps
    rand_delay = 1'b1;
    stray_en = 1'b1;
    s_data.delete();
    s_gap.delete();
    s_busy.delete();
    for (int i = 0; i < 40; i++) begin
      s_data.push_back(8'($urandom));
      s_gap.push_back($urandom_range(0, 3));
      s_busy.push_back($urandom_range(0, 3));
    end
    run_stream("rand");
    rand_delay = 1'b0;
    stray_en = 1'b0;

    // Reset during the DLM request, 3-cycle slave
    ack_delay = 3;
    do_reset(2);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (bus_req && bus_we && bus_addr == A_DLM && log_q.size() == 2) found = 1'b1;
    end
    check("rst_dlm_reached", 32'(found), 32'd1);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_dlm_req_low", 32'(bus_req), 32'd0);
    check("rst_dlm_init_done", 32'(init_done), 32'd0);
    #1;
    rst = 1'b0;
    log_q.delete();
    wait_init("rst_dlm", 25);
    build_init_exp();
    compare_log("rst_dlm");

    // Reset during a WR_THR wait: byte is abandoned and init restarts
    @(negedge clk);
    lsr_q.delete();
    lsr_q.push_back(8'h60);
    rt0 = ready_total;
    tx_data = 8'h77;
    tx_valid = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (bus_req && bus_we && bus_addr == A_THR) found = 1'b1;
    end
    check("rst_thr_reached", 32'(found), 32'd1);
    #1;
    rst = 1'b1;
    tx_valid = 1'b0;
    @(negedge clk);
    check("rst_thr_req_low", 32'(bus_req), 32'd0);
    check("rst_thr_init_done", 32'(init_done), 32'd0);
    #1;
    rst = 1'b0;
    log_q.delete();
    wait_init("rst_thr", 25);
    build_init_exp();
    compare_log("rst_thr");
    check("rst_thr_no_ready", ready_total - rt0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
